// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues in-order word reads to
// instruction memory, buffers returned words and presents them (with PC and
// decoded opcode/funct fields) to decode over a valid/ready handshake.
// Redirects flush all wrong-path work; stale responses are drained.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  // PCs of requests accepted by memory but not yet answered
  logic [XLEN-1:0] pcq [DEPTH];
  logic [PW-1:0]   pcq_head;
  logic [PW-1:0]   pcq_tail;

  // returned instructions waiting for decode
  logic [XLEN-1:0] buf_data [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [PW-1:0]   buf_rd;
  logic [PW-1:0]   buf_wr;
  logic [CW-1:0]   buf_count;

  logic [CW:0]     occupancy;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            rsp_any;
  logic            pop;
  logic [CW-1:0]   inflight_after;

  // credit check, handshake qualifiers and redirect drop count
  always_comb begin
    occupancy      = {1'b0, outstanding} + {1'b0, buf_count};
    credit_ok      = occupancy < (CW+1)'(DEPTH);
    imem_req_valid = !rst && (state == RUN) && credit_ok && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (state == RUN) && (outstanding != '0) && !redirect_valid;
    rsp_drop       = imem_rsp_valid && (state == DRAIN) && (drop_cnt != '0);
    rsp_any        = imem_rsp_valid && ((outstanding != '0) || (drop_cnt != '0));
    // a response landing in the redirect cycle is discarded here, so it is
    // not counted among the responses still to be drained
    inflight_after = outstanding + drop_cnt - CW'(rsp_any);
    pop            = inst_valid && inst_ready && !redirect_valid;
  end

  // PC, run/drain state and stale-response counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= RUN;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= inflight_after;
      state    <= (inflight_after != '0) ? DRAIN : RUN;
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
        if (drop_cnt == CW'(1)) state <= RUN;
      end
    end
  end

  // in-flight request pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcq_head    <= '0;
      pcq_tail    <= '0;
      outstanding <= '0;
    end else if (redirect_valid) begin
      pcq_head    <= '0;
      pcq_tail    <= '0;
      outstanding <= '0;
    end else begin
      if (req_fire) pcq_tail <= pcq_tail + PW'(1);
      if (rsp_take) pcq_head <= pcq_head + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
    end
  end

  // in-flight PC storage
  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_tail] <= pc;
  end

  // instruction buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_rd    <= '0;
      buf_wr    <= '0;
      buf_count <= '0;
    end else if (redirect_valid) begin
      buf_rd    <= '0;
      buf_wr    <= '0;
      buf_count <= '0;
    end else begin
      if (rsp_take) buf_wr <= buf_wr + PW'(1);
      if (pop)      buf_rd <= buf_rd + PW'(1);
      buf_count <= buf_count + CW'(rsp_take) - CW'(pop);
    end
  end

  // instruction buffer storage
  always_ff @(posedge clk) begin
    if (rsp_take) begin
      buf_data[buf_wr] <= imem_rsp_data;
      buf_pc[buf_wr]   <= pcq[pcq_head];
    end
  end

  assign imem_req_addr = pc;
  assign inst_valid    = (buf_count != '0);
  assign inst_data     = buf_data[buf_rd];
  assign inst_pc       = buf_pc[buf_rd];
  assign opcode        = inst_data[6:0];
  assign funct3        = inst_data[14:12];
  assign funct7        = inst_data[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a randomized memory model feeds the DUT,
// accepted correct-path fetches push expected {pc,data} into a queue, and a
// negedge monitor pops and compares every instruction decode consumes.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mreq_t pend[$];
  exp_t  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cnt = 0;

  // stimulus knobs
  int lat_min = 1, lat_max = 1;
  int rdy_pct = 100, irdy_pct = 100, redir_pct = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc    = '0;

  // reference PC stream
  logic [31:0] exp_req = 32'h0;

  // negedge samples handed to the driver
  bit          s_acc = 1'b0, s_rsp = 1'b0, s_redir = 1'b0, prev_redir = 1'b0;
  logic [31:0] s_addr = '0, s_rpc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: sample handshakes and score consumed instructions
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_redir = 1'b0;
        s_acc = 1'b0; s_rsp = 1'b0; s_redir = 1'b0;
      end else begin
        s_acc   = imem_req_valid && imem_req_ready;
        s_addr  = imem_req_addr;
        s_rsp   = imem_rsp_valid;
        s_redir = redirect_valid;
        s_rpc   = redirect_pc;
        if (prev_redir) check("inst_valid_after_redirect", {31'b0, inst_valid}, 32'h0);
        if (redirect_valid) check("no_req_on_redirect", {31'b0, imem_req_valid}, 32'h0);
        if (inst_valid && inst_ready) begin
          check("inst_expected", {31'b0, exp_q.size() != 0}, 32'h1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e.pc);
            check("inst_data", inst_data, e.data);
            check("opcode", {25'b0, opcode}, {25'b0, e.data[6:0]});
            check("funct3", {29'b0, funct3}, {29'b0, e.data[14:12]});
            check("funct7", {25'b0, funct7}, {25'b0, e.data[31:25]});
          end
        end
        prev_redir = redirect_valid;
      end
    end
  end

  // one clock of memory model, reference update and random input drive
  task automatic step();
    int lat;
    logic [31:0] t;
    @(posedge clk);
    #1;
    cyc++;
    if (s_acc) begin
      acc_cnt++;
      check("req_addr", s_addr, exp_req);
      lat = $urandom_range(lat_max, lat_min);
      pend.push_back('{exp_req, cyc + lat - 1});
      exp_q.push_back('{exp_req, mem_word(exp_req)});
      exp_req = exp_req + 32'd4;
      check("inflight_limit", {31'b0, pend.size() <= DEPTH}, 32'h1);
    end
    if (s_rsp && pend.size() != 0) void'(pend.pop_front());
    if (s_redir) begin
      exp_q.delete();
      exp_req = {s_rpc[31:2], 2'b00};
    end
    imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    inst_ready = ($urandom_range(99, 0) < irdy_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if ($urandom_range(99, 0) < redir_pct) begin
      t = $urandom;
      if ($urandom_range(9, 0) == 0) t = 32'hFFFFFFF0 | ($urandom & 32'hF);
      redirect_valid = 1'b1;
      redirect_pc    = t;
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("reset_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("reset_req_addr", imem_req_addr, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // steady streaming from reset with a 1-cycle memory
    run(40);

    // decode stalled right after a redirect: exactly DEPTH fetches go out
    irdy_pct = 0; force_redir = 1'b1; force_pc = 32'h200;
    step();
    step();
    acc_cnt = 0;
    run(12);
    check("stall_issue_count", acc_cnt, DEPTH);
    irdy_pct = 100;
    run(20);

    // redirect to unaligned 0x103 with two requests in flight
    lat_min = 3; lat_max = 3;
    k = 0;
    while (pend.size() != 2 && k < 50) begin step(); k++; end
    check("two_in_flight", pend.size(), 2);
    force_redir = 1'b1; force_pc = 32'h103;
    run(30);

    // PC wrap-around past 0xFFFFFFFC with random latency and stalls
    lat_min = 1; lat_max = 4; rdy_pct = 70; irdy_pct = 70;
    force_redir = 1'b1; force_pc = 32'hFFFFFFF4;
    run(30);

    // fully random traffic with redirects
    redir_pct = 5;
    run(1500);

    // quiesce: stop accepting fetches and let everything drain out
    redir_pct = 0; rdy_pct = 0; irdy_pct = 100;
    k = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && k < 200) begin step(); k++; end
    check("drain_exp_queue", exp_q.size(), 0);
    check("drain_mem_pending", pend.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
